sdram_axi_burst_master: RTL
===========================

// Module: sdram_axi_burst_master
// PURPOSE
//  AXI4 initiator that turns simple burst commands into single INCR bursts on an AXI4 port,
//  driving the SDRAM AXI slave (inport_* side) from DMA/test logic. One outstanding
//  transaction; write data streamed in, read data streamed out, one status pulse per command.
// PARAMETERS
//  AXI_ID    4'd0  value driven on awid/arid; rid/bid must match
//  CHECK_4K  1     1: reject bursts crossing a 4KB boundary
// PORTS
//  clk_i  in 1  clock
//  rst_i  in 1  asynchronous reset, active-high
//  cmd_valid_i in 1, cmd_ready_o out 1   command handshake
//  cmd_write_i in 1   1=write burst, 0=read burst
//  cmd_addr_i  in 32  byte address, must be 4-byte aligned
//  cmd_len_i   in 8   beats-1 (AXI len encoding)
//  wr_valid_i in 1, wr_ready_o out 1, wr_data_i in 32, wr_strb_i in 4   write data stream
//  rd_valid_o out 1, rd_ready_i in 1, rd_data_o out 32, rd_last_o out 1   read data stream
//  done_o out 1   one-cycle completion pulse;  err_o out 1  status, valid with done_o
//  outport_awvalid_o out 1, awready_i in 1, awaddr_o out 32, awid_o out 4, awlen_o out 8, awburst_o out 2
//  outport_wvalid_o out 1, wready_i in 1, wdata_o out 32, wstrb_o out 4, wlast_o out 1
//  outport_bvalid_i in 1, bready_o out 1, bresp_i in 2, bid_i in 4
//  outport_arvalid_o out 1, arready_i in 1, araddr_o out 32, arid_o out 4, arlen_o out 8, arburst_o out 2
//  outport_rvalid_i in 1, rready_o out 1, rdata_i in 32, rresp_i in 2, rid_i in 4, rlast_i in 1
// BEHAVIOUR
//  Reset: state IDLE; all *valid_o, bready_o, rready_o, done_o, err_o, rd_last_o = 0;
//   registered addr/len/id outputs = 0. Reset mid-burst aborts silently (no done_o).
//  FSM: IDLE -> CHK -> {AW -> WDATA -> BRESP | AR -> RDATA} -> IDLE.
//  IDLE: cmd_ready_o=1; on cmd_valid_i latch write/addr/len, go CHK. cmd_ready_o=0 elsewhere.
//  CHK (1 cycle): addr[1:0]!=0, or CHECK_4K && addr[11:0]+4*(len+1) > 4096 (13-bit sum)
//   -> done_o=1, err_o=1, back to IDLE, no AXI traffic. Else AW (write) or AR (read).
//  AW/AR: valid held high with stable fields until ready; awburst/arburst=2'b01, id=AXI_ID.
//   Address phase handshake required before first W beat (no W-before-AW).
//  WDATA: wvalid_o=wr_valid_i, wr_ready_o=wready_i (combinational pass-through, data/strb
//   pass-through); 8-bit beat counter from 0; wlast_o=(count==len); on last handshake -> BRESP.
//  BRESP: bready_o=1; on bvalid_i: err=(bresp_i!=0)|(bid_i!=AXI_ID); done_o pulse; IDLE.
//  RDATA: rd_valid_o=rvalid_i, rready_o=rd_ready_i, rd_data_o=rdata_i; rd_last_o=(count==len).
//   Per accepted beat: sticky err |= rresp_i!=0 | rid_i!=AXI_ID | (rlast_i != (count==len)).
//   On beat count==len accepted: done_o pulse with sticky err; IDLE. All beats always forwarded.
//  done_o/err_o: registered, asserted exactly one cycle after the final handshake; err_o=0 when
//   done_o=0. Next command accepted in the cycle done_o is high (state already IDLE).
//  len=0: single beat, wlast_o/rd_last_o high on beat 0. len=255: counter must not wrap early.
//  Upstream stall (wr_valid_i low / rd_ready_i low) stalls beats indefinitely; no timeout.
// TESTING
//  Write addr=0x100 len=3 data 0xA0..A3 -> AW 0x100/len3/burst1; 4 W beats, wlast on 4th;
//   bresp=0 -> done_o=1 err_o=0 one cycle after B handshake.
//  Read addr=0x200 len=7, rd_ready_i toggling every cycle -> 8 beats in order, rd_last_o on 8th,
//   rready_o mirrors rd_ready_i, done_o err_o=0.
//  awready_i/arready_i low 5 cycles -> valid stays high, addr/len stable, then proceeds.
//  addr=0xFF8 len=3 -> no AW, done_o=1 err_o=1 two cycles after cmd accept; addr=0x102 same.
//  bresp=2'b10 -> err_o=1; read len=3 with rresp=2 on beat 1 -> 4 beats delivered, err_o=1.
//  rst_i asserted mid write burst (beat 2 of 8) -> all valids low async, no done_o, new cmd ok.

Source files
------------

// File: rtl/sdram_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one command in, one AXI burst out,
// write beats streamed through from wr_*, read beats streamed out on rd_*, one done pulse.
module sdram_axi_burst_master #(
  parameter logic [3:0] AXI_ID   = 4'd0,
  parameter bit         CHECK_4K = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [31:0] rd_data_o,
  output logic        rd_last_o,
  output logic        done_o,
  output logic        err_o,
  output logic        outport_awvalid_o,
  input  logic        outport_awready_i,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  input  logic        outport_wready_i,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_bvalid_i,
  output logic        outport_bready_o,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i
);

  typedef enum logic [2:0] {IDLE, CHK, AW, WDATA, BRESP, AR, RDATA} state_t;

  state_t      state_reg, state_next;
  logic        write_reg, write_next;
  logic [31:0] addr_reg, addr_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  count_reg, count_next;
  logic [3:0]  id_reg, id_next;
  logic        sticky_reg, sticky_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  logic        last_beat;
  logic        bad_align;
  logic        crosses_4k;
  logic [12:0] span;
  logic [12:0] end_offset;
  logic        beat_err;

  assign last_beat  = (count_reg == len_reg);
  assign bad_align  = (addr_reg[1:0] != 2'b00);
  // 13-bit sum so a 256-beat burst from offset 0xFFC cannot overflow the compare
  assign span       = ({5'd0, len_reg} + 13'd1) << 2;
  assign end_offset = {1'b0, addr_reg[11:0]} + span;
  assign crosses_4k = CHECK_4K && (end_offset > 13'd4096);
  assign beat_err   = (outport_rresp_i != 2'b00) || (outport_rid_i != AXI_ID) ||
                      (outport_rlast_i != last_beat);

  assign outport_awaddr_o  = addr_reg;
  assign outport_awlen_o   = len_reg;
  assign outport_awid_o    = id_reg;
  assign outport_awburst_o = 2'b01;
  assign outport_araddr_o  = addr_reg;
  assign outport_arlen_o   = len_reg;
  assign outport_arid_o    = id_reg;
  assign outport_arburst_o = 2'b01;
  assign outport_wdata_o   = wr_data_i;
  assign outport_wstrb_o   = wr_strb_i;
  assign rd_data_o         = outport_rdata_i;
  assign done_o            = done_reg;
  assign err_o             = err_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      len_reg    <= '0;
      count_reg  <= '0;
      id_reg     <= '0;
      sticky_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      count_reg  <= count_next;
      id_reg     <= id_next;
      sticky_reg <= sticky_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    write_next        = write_reg;
    addr_next         = addr_reg;
    len_next          = len_reg;
    count_next        = count_reg;
    id_next           = id_reg;
    sticky_next       = sticky_reg;
    done_next         = 1'b0;
    err_next          = 1'b0;
    cmd_ready_o       = 1'b0;
    wr_ready_o        = 1'b0;
    rd_valid_o        = 1'b0;
    rd_last_o         = 1'b0;
    outport_awvalid_o = 1'b0;
    outport_wvalid_o  = 1'b0;
    outport_wlast_o   = 1'b0;
    outport_bready_o  = 1'b0;
    outport_arvalid_o = 1'b0;
    outport_rready_o  = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          write_next  = cmd_write_i;
          addr_next   = cmd_addr_i;
          len_next    = cmd_len_i;
          id_next     = AXI_ID;
          count_next  = 8'd0;
          sticky_next = 1'b0;
          state_next  = CHK;
        end
      end
      CHK: begin
        if (bad_align || crosses_4k) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = write_reg ? AW : AR;
        end
      end
      AW: begin
        outport_awvalid_o = 1'b1;
        if (outport_awready_i) state_next = WDATA;
      end
      WDATA: begin
        outport_wvalid_o = wr_valid_i;
        wr_ready_o       = outport_wready_i;
        outport_wlast_o  = last_beat;
        if (wr_valid_i && outport_wready_i) begin
          count_next = count_reg + 8'd1;
          if (last_beat) state_next = BRESP;
        end
      end
      BRESP: begin
        outport_bready_o = 1'b1;
        if (outport_bvalid_i) begin
          done_next  = 1'b1;
          err_next   = (outport_bresp_i != 2'b00) || (outport_bid_i != AXI_ID);
          state_next = IDLE;
        end
      end
      AR: begin
        outport_arvalid_o = 1'b1;
        if (outport_arready_i) state_next = RDATA;
      end
      RDATA: begin
        rd_valid_o       = outport_rvalid_i;
        outport_rready_o = rd_ready_i;
        rd_last_o        = last_beat;
        if (outport_rvalid_i && rd_ready_i) begin
          sticky_next = sticky_reg | beat_err;
          count_next  = count_reg + 8'd1;
          if (last_beat) begin
            done_next  = 1'b1;
            err_next   = sticky_reg | beat_err;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
